face_capture_ctrl: RTL and testbench

FACE_CAPTURE_CTRL -- requirements
Module: face_capture_ctrl

---
 rtl/face_capture_ctrl_if.sv | 38 +++
 rtl/face_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_face_capture_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/face_capture_ctrl_if.sv
// face_capture_ctrl_if
// Purpose: groups the capture handshake, the CCD timing strobes and the
// datapath control lines of the face capture controller into one bundle.
// Signals:
//   start, abort, ack   : capture request / abort / result acknowledge
//   fval, lval, hit     : CCD frame-valid, line-valid, sample-window strobe
//   acc_clear, acc_en   : datapath accumulator clear pulse and enable
//   busy, done, error   : controller status
//   face_idx, frame_cnt : current face, frames completed in this capture
//   hit_cnt             : hits counted in the current frame
// Modports: master drives the requests and the CCD strobes and observes the
// status; slave is the controller itself.
interface face_capture_ctrl_if;
  logic       start;
  logic       abort;
  logic       ack;
  logic       fval;
  logic       lval;
  logic       hit;
  logic       acc_clear;
  logic       acc_en;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] face_idx;
  logic [2:0] frame_cnt;
  logic [5:0] hit_cnt;

  modport master (
    output start, abort, ack, fval, lval, hit,
    input  acc_clear, acc_en, busy, done, error, face_idx, frame_cnt, hit_cnt
  );

  modport slave (
    input  start, abort, ack, fval, lval, hit,
    output acc_clear, acc_en, busy, done, error, face_idx, frame_cnt, hit_cnt
  );
endinterface

// File: rtl/face_capture_ctrl.sv
// face_capture_ctrl
// Purpose: sequences the capture of one cube face. After a start request it
// waits for a frame boundary, then accumulates NUM_FRAMES whole frames,
// checking that every frame produced exactly HITS_PER_FRAME sample hits.
// A good capture ends in DONE and advances the face index; a bad one ends in
// ERROR and keeps the face index so the same face is retried.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : face_capture_ctrl_if.slave (handshake, CCD strobes, status)
module face_capture_ctrl #(
  parameter int NUM_FRAMES     = 4,
  parameter int HITS_PER_FRAME = 45,
  parameter int NUM_FACES      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  face_capture_ctrl_if.slave bus
);

  localparam logic [2:0] FRAMES_LAST = 3'(NUM_FRAMES);
  localparam logic [5:0] HITS_EXP    = 6'(HITS_PER_FRAME);
  localparam logic [2:0] FACE_LAST   = 3'(NUM_FACES - 1);

  typedef enum logic [2:0] {
    IDLE, ARM, SYNC, ACCUM, CHECK, DONE, ERROR
  } state_t;

  state_t     state, next_state;
  logic       fval_d;
  logic [5:0] hit_cnt;
  logic [2:0] frame_cnt;
  logic [2:0] face_idx;
  logic       acc_clear_q;
  logic       done_q;
  logic       error_q;
  logic       acc_en;
  logic       start_capture;
  logic       fval_rise;
  logic       fval_fall;
  logic       hits_ok;
  logic       last_frame;

  assign fval_rise  = bus.fval & ~fval_d;
  assign fval_fall  = ~bus.fval & fval_d;
  assign hits_ok    = (hit_cnt == HITS_EXP);
  assign last_frame = ((frame_cnt + 3'd1) == FRAMES_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode. Abort overrides every transition, including a start
  // in IDLE, so an aborted request never produces an accumulator clear.
  always_comb begin
    next_state    = state;
    acc_en        = 1'b0;
    start_capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state    = ARM;
          start_capture = 1'b1;
        end
      end
      ARM: begin
        if (!bus.fval) next_state = SYNC;
      end
      SYNC: begin
        if (fval_rise) next_state = ACCUM;
      end
      ACCUM: begin
        acc_en = bus.fval & bus.lval;
        if (fval_fall) next_state = CHECK;
      end
      CHECK: begin
        if (!hits_ok)       next_state = ERROR;
        else if (last_frame) next_state = DONE;
        else                next_state = SYNC;
      end
      DONE: begin
        if (bus.ack) next_state = IDLE;
      end
      ERROR: begin
        if (bus.ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (bus.abort) begin
      next_state    = IDLE;
      start_capture = 1'b0;
    end
  end

  // Counters and registered outputs. Done/Error follow the next state so they
  // are high exactly while the FSM sits in DONE/ERROR, and drop the cycle
  // after the acknowledge is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fval_d      <= 1'b0;
      hit_cnt     <= 6'd0;
      frame_cnt   <= 3'd0;
      face_idx    <= 3'd0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      fval_d      <= bus.fval;
      acc_clear_q <= start_capture;
      done_q      <= (next_state == DONE);
      error_q     <= (next_state == ERROR);
      if (bus.abort) begin
        hit_cnt   <= 6'd0;
        frame_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              hit_cnt   <= 6'd0;
              frame_cnt <= 3'd0;
            end
          end
          SYNC: begin
            if (fval_rise) hit_cnt <= 6'd0;
          end
          ACCUM: begin
            if (acc_en && bus.hit && (hit_cnt != 6'd63)) hit_cnt <= hit_cnt + 6'd1;
          end
          CHECK: begin
            if (hits_ok) frame_cnt <= frame_cnt + 3'd1;
          end
          DONE: begin
            if (bus.ack) face_idx <= (face_idx == FACE_LAST) ? 3'd0 : face_idx + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.acc_clear = acc_clear_q;
  assign bus.acc_en    = acc_en;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.face_idx  = face_idx;
  assign bus.frame_cnt = frame_cnt;
  assign bus.hit_cnt   = hit_cnt;

endmodule

// File: tb/tb_face_capture_ctrl.sv
// tb_face_capture_ctrl
// Purpose: directed self-checking bench for face_capture_ctrl with the
// default parameters (4 frames, 45 hits per frame, 6 faces).
module tb_face_capture_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   clear_count;

  face_capture_ctrl_if bus ();

  face_capture_ctrl #(
    .NUM_FRAMES    (4),
    .HITS_PER_FRAME(45),
    .NUM_FACES     (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts accumulator clear pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.acc_clear === 1'b1) clear_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0;
    bus.fval  = 1'b0; bus.lval  = 1'b0; bus.hit = 1'b0;
  endtask

  // One CCD frame: gap, rising edge, nhits counted hits, stray hits with
  // lval low, a quiet line cycle, then the falling edge carrying an ignored
  // hit. Returns with the controller sitting in CHECK.
  task automatic gen_frame(input int nhits, input int stray);
    bus.fval = 1'b0; bus.lval = 1'b0; bus.hit = 1'b0;
    tick(); tick();
    bus.fval = 1'b1;
    tick();
    for (int i = 0; i < nhits; i++) begin
      bus.lval = 1'b1; bus.hit = 1'b1; tick();
    end
    for (int i = 0; i < stray; i++) begin
      bus.lval = 1'b0; bus.hit = 1'b1; tick();
    end
    bus.lval = 1'b1; bus.hit = 1'b0; tick();
    bus.fval = 1'b0; bus.lval = 1'b1; bus.hit = 1'b1; tick();
    bus.lval = 1'b0; bus.hit = 1'b0;
  endtask

  task automatic start_capture();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b want 0", bus.busy); end
    tests_run++; if (bus.acc_clear !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_acc_clear: got %b want 0", bus.acc_clear); end
    tests_run++; if (bus.acc_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_acc_en: got %b want 0", bus.acc_en); end
    tests_run++; if (bus.done !== 1'b0 || bus.error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_done_error: got %b%b want 00", bus.done, bus.error); end
    tests_run++; if (bus.face_idx !== 3'd0 || bus.frame_cnt !== 3'd0 || bus.hit_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL rst_counters: got face %0d frame %0d hit %0d want 0 0 0", bus.face_idx, bus.frame_cnt, bus.hit_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    clear_count = 0;
    start_capture();
    tests_run++; if (bus.acc_clear !== 1'b1) begin tests_failed++; $display("[TB] FAIL nom_clear_pulse: got %b want 1", bus.acc_clear); end
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL nom_busy: got %b want 1", bus.busy); end
    tick();
    tests_run++; if (bus.acc_clear !== 1'b0) begin tests_failed++; $display("[TB] FAIL nom_clear_drop: got %b want 0", bus.acc_clear); end
    for (int f = 0; f < 4; f++) begin
      gen_frame(45, 0);
      tests_run++; if (bus.hit_cnt !== 6'd45) begin tests_failed++; $display("[TB] FAIL nom_hits f%0d: got %0d want 45", f, bus.hit_cnt); end
      tick();
      tests_run++; if (bus.frame_cnt !== 3'(f + 1)) begin tests_failed++; $display("[TB] FAIL nom_frame f%0d: got %0d want %0d", f, bus.frame_cnt, f + 1); end
      tests_run++; if (bus.done !== (f == 3)) begin tests_failed++; $display("[TB] FAIL nom_done f%0d: got %b want %b", f, bus.done, (f == 3)); end
    end
    tick(); tick();
    tests_run++; if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.face_idx !== 3'd0) begin tests_failed++; $display("[TB] FAIL nom_done_hold: got done %b err %b face %0d want 1 0 0", bus.done, bus.error, bus.face_idx); end
    tests_run++; if (clear_count !== 1) begin tests_failed++; $display("[TB] FAIL nom_clear_count: got %0d want 1", clear_count); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.face_idx !== 3'd1) begin tests_failed++; $display("[TB] FAIL nom_ack: got done %b busy %b face %0d want 0 0 1", bus.done, bus.busy, bus.face_idx); end
  endtask

  task automatic test_midframe();
    bus.fval = 1'b1; tick();
    start_capture();
    for (int i = 0; i < 6; i++) begin
      bus.lval = 1'b1; bus.hit = 1'b1; tick();
    end
    tests_run++; if (bus.hit_cnt !== 6'd0 || bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_partial: got hit %0d busy %b want 0 1", bus.hit_cnt, bus.busy); end
    bus.fval = 1'b0; bus.lval = 1'b0; bus.hit = 1'b0; tick();
    gen_frame(45, 0);
    tests_run++; if (bus.hit_cnt !== 6'd45) begin tests_failed++; $display("[TB] FAIL mid_hits: got %0d want 45", bus.hit_cnt); end
    tick();
    tests_run++; if (bus.frame_cnt !== 3'd1 || bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_frame: got frame %0d busy %b want 1 1", bus.frame_cnt, bus.busy); end
    clear_count = 0;
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    tests_run++; if (bus.busy !== 1'b0 || bus.frame_cnt !== 3'd0 || bus.face_idx !== 3'd1) begin tests_failed++; $display("[TB] FAIL mid_abort: got busy %b frame %0d face %0d want 0 0 1", bus.busy, bus.frame_cnt, bus.face_idx); end
    tick();
    tests_run++; if (clear_count !== 0) begin tests_failed++; $display("[TB] FAIL mid_abort_clear: got %0d want 0", clear_count); end
  endtask

  task automatic test_mismatch();
    start_capture();
    gen_frame(45, 0); tick();
    tests_run++; if (bus.frame_cnt !== 3'd1) begin tests_failed++; $display("[TB] FAIL mis_frame1: got %0d want 1", bus.frame_cnt); end
    gen_frame(44, 3);
    tests_run++; if (bus.hit_cnt !== 6'd44) begin tests_failed++; $display("[TB] FAIL mis_hits: got %0d want 44", bus.hit_cnt); end
    tick();
    tests_run++; if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.frame_cnt !== 3'd1) begin tests_failed++; $display("[TB] FAIL mis_error: got err %b done %b frame %0d want 1 0 1", bus.error, bus.done, bus.frame_cnt); end
    tick();
    tests_run++; if (bus.error !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_error_hold: got %b want 1", bus.error); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    tests_run++; if (bus.error !== 1'b0 || bus.busy !== 1'b0 || bus.face_idx !== 3'd1) begin tests_failed++; $display("[TB] FAIL mis_ack: got err %b busy %b face %0d want 0 0 1", bus.error, bus.busy, bus.face_idx); end
  endtask

  task automatic test_saturate();
    start_capture();
    gen_frame(70, 0);
    tests_run++; if (bus.hit_cnt !== 6'd63) begin tests_failed++; $display("[TB] FAIL sat_hits: got %0d want 63", bus.hit_cnt); end
    tick();
    tests_run++; if (bus.error !== 1'b1 || bus.frame_cnt !== 3'd0) begin tests_failed++; $display("[TB] FAIL sat_error: got err %b frame %0d want 1 0", bus.error, bus.frame_cnt); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    tests_run++; if (bus.busy !== 1'b0 || bus.face_idx !== 3'd1) begin tests_failed++; $display("[TB] FAIL sat_ack: got busy %b face %0d want 0 1", bus.busy, bus.face_idx); end
  endtask

  task automatic test_ignored_abort();
    start_capture();
    tick();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    tests_run++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.face_idx !== 3'd1 || bus.hit_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL ign_ack_sync: got busy %b done %b err %b face %0d hit %0d want 1 0 0 1 0", bus.busy, bus.done, bus.error, bus.face_idx, bus.hit_cnt); end
    bus.fval = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      bus.lval = 1'b1; bus.hit = 1'b1; tick();
    end
    bus.lval = 1'b0; bus.hit = 1'b0;
    clear_count = 0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tests_run++; if (bus.hit_cnt !== 6'd10 || bus.busy !== 1'b1 || bus.acc_clear !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_start_accum: got hit %0d busy %b clr %b want 10 1 0", bus.hit_cnt, bus.busy, bus.acc_clear); end
    bus.lval = 1'b1; #1;
    tests_run++; if (bus.acc_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL accen_high: got %b want 1", bus.acc_en); end
    bus.lval = 1'b0; #1;
    tests_run++; if (bus.acc_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL accen_low: got %b want 0", bus.acc_en); end
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.lval = 1'b1; bus.hit = 1'b1; tick();
    end
    bus.lval = 1'b0; bus.hit = 1'b0;
    tests_run++; if (bus.hit_cnt !== 6'd20) begin tests_failed++; $display("[TB] FAIL abort_pre_hits: got %0d want 20", bus.hit_cnt); end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    tests_run++; if (bus.busy !== 1'b0 || bus.hit_cnt !== 6'd0 || bus.frame_cnt !== 3'd0 || bus.face_idx !== 3'd1) begin tests_failed++; $display("[TB] FAIL abort_accum: got busy %b hit %0d frame %0d face %0d want 0 0 0 1", bus.busy, bus.hit_cnt, bus.frame_cnt, bus.face_idx); end
    bus.lval = 1'b1; #1;
    tests_run++; if (bus.acc_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL accen_idle: got %b want 0", bus.acc_en); end
    bus.fval = 1'b0; bus.lval = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b1; tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    tests_run++; if (bus.acc_clear !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL start_abort: got clr %b busy %b want 0 0", bus.acc_clear, bus.busy); end
    tick();
    tests_run++; if (bus.busy !== 1'b0 || clear_count !== 0) begin tests_failed++; $display("[TB] FAIL start_abort_after: got busy %b clears %0d want 0 0", bus.busy, clear_count); end
  endtask

  task automatic test_reset_mid();
    start_capture();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0 || bus.acc_clear !== 1'b0 || bus.acc_en !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_flags: got busy %b clr %b en %b done %b err %b want 0", bus.busy, bus.acc_clear, bus.acc_en, bus.done, bus.error); end
    tests_run++; if (bus.face_idx !== 3'd0 || bus.frame_cnt !== 3'd0 || bus.hit_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL rmid_counters: got face %0d frame %0d hit %0d want 0 0 0", bus.face_idx, bus.frame_cnt, bus.hit_cnt); end
    rst_n = 1'b1;
    gen_frame(45, 0); tick(); tick();
    tests_run++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.hit_cnt !== 6'd0) begin tests_failed++; $display("[TB] FAIL rmid_after: got busy %b done %b err %b hit %0d want 0 0 0 0", bus.busy, bus.done, bus.error, bus.hit_cnt); end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 6; c++) begin
      start_capture();
      for (int f = 0; f < 4; f++) begin
        gen_frame(45, 0); tick();
      end
      tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_done c%0d: got %b want 1", c, bus.done); end
      bus.ack = 1'b1; tick(); bus.ack = 1'b0;
      tests_run++; if (bus.face_idx !== 3'((c + 1) % 6)) begin tests_failed++; $display("[TB] FAIL wrap_face c%0d: got %0d want %0d", c, bus.face_idx, (c + 1) % 6); end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_count  = 0;
    test_reset();
    test_nominal();
    test_midframe();
    test_mismatch();
    test_saturate();
    test_ignored_abort();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
